pipa_moding_source: RTL and testbench
=====================================

PIPA_MODING_SOURCE -- requirements
Module: pipa_moding_source

Interface
REQ-001 Parameter CREDIT_W, default 8, width of each axis's signed frame-credit register.
REQ-002 Parameter SYNC_STAGES, default 2, number of PIPASW synchronizer flops.
REQ-003 SIM_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SIM_RST  input  1  reset, synchronous, active-high.
REQ-005 PIPASW  input  1  AGC PIPA sample strobe; asynchronous to SIM_CLK.
REQ-006 PIPDAT  input  1  AGC PIPA data-gate window; gates output pulses combinationally.
REQ-007 moding_en  input  1  1 = IMU operating, pulses emitted; 0 = all PIPA outputs forced 0.
REQ-008 load_valid  input  1  credit-load request.
REQ-009 load_axis  input  2  0 = X, 1 = Y, 2 = Z, 3 = invalid.
REQ-010 load_delta  input  CREDIT_W  signed two's-complement frame credits to add.
REQ-011 load_ready  output  1  high whenever SIM_RST is low.
REQ-012 load_err  output  1  one-cycle pulse when load_valid is high with load_axis = 3.
REQ-013 PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm  output  1 each  PIPA plus/minus pulse lines to the AGC.
REQ-014 busy  output  3  bit n high when axis n credit is nonzero (bit 0 = X).
REQ-015 frame_count  output  16  number of completed 6-slot frames; wraps modulo 2^16.

Function
REQ-016 PIPASW SHALL pass through SYNC_STAGES flops plus one edge-detect flop; a rising edge yields a one-cycle slot_tick SYNC_STAGES+1 SIM_CLK cycles after it.
REQ-017 On slot_tick, the 3-bit slot counter SHALL advance 0..5 and wrap 5->0; values 6 and 7 are unreachable.
REQ-018 On a slot_tick that wraps 5->0, frame_count SHALL increment and each axis SHALL latch its frame pattern nplus (2, 3 or 4) from its current credit.
REQ-019 Pattern selection: credit > 0 gives nplus = 4 (net +2) and credit decrements by 1; credit < 0 gives nplus = 2 (net -2) and credit increments by 1; credit = 0 gives nplus = 3 (3-3 moding).
REQ-020 The latched nplus SHALL be held constant for the whole frame (slots 0-5).
REQ-021 PIPAnp = moding_en & PIPDAT & (slot < nplus_n); PIPAnm = moding_en & PIPDAT & (slot >= nplus_n). The PIPDAT path SHALL be combinational with no register.
REQ-022 Accepted loads (load_valid & load_ready, axis 0-2) SHALL add load_delta to that axis's credit, effective the next cycle.
REQ-023 Credit arithmetic SHALL saturate at +(2^(CREDIT_W-1)-1) and -(2^(CREDIT_W-1)-1); the value -2^(CREDIT_W-1) SHALL never be stored.
REQ-024 If a load and a frame-boundary step hit the same axis in one cycle, the result SHALL be credit + delta - sign(credit), saturated once.
REQ-025 An invalid-axis load SHALL change no credit and SHALL pulse load_err.
REQ-026 When moding_en = 0, slot and frame tracking and credit updates SHALL continue; only the outputs are masked.
REQ-027 busy SHALL reflect the registered credits, with no lookahead.

Reset
REQ-028 While SIM_RST is high: slot = 0, frame_count = 0, all credits = 0, all nplus = 3, synchronizer and edge flops = 0, load_ready = 0, load_err = 0, busy = 0.
REQ-029 Loads presented during reset SHALL be discarded.
REQ-030 A reset asserted mid-frame SHALL abandon the frame; the first slot_tick after release SHALL move slot from 0 to 1.

Verification
REQ-031 After reset, with moding_en = 1 and no loads, toggle PIPASW for 12 edges with PIPDAT high each slot -> per axis per frame exactly 3 plus then 3 minus pulses; frame_count = 2.
REQ-032 Load X +2 at slot 3 of frame 0 -> frames 1 and 2 give X 4 plus / 2 minus, frame 3 gives 3/3; busy[0] falls at the frame 2 boundary; Y and Z stay 3/3.
REQ-033 Load Z +127, then load Z +5 -> credit_Z = 127; load Y -128 -> credit_Y = -127.
REQ-034 Load X +1 on the exact cycle of the 5->0 slot_tick while credit_X = 3 -> credit_X = 3 and the frame pattern is 4/2.
REQ-035 load_axis = 3 with delta 10 -> load_err pulses for one cycle; all credits unchanged.
REQ-036 Raise SIM_RST at slot 4 with credit_X = 5 -> after release slot = 0, credit_X = 0, pattern 3/3, frame_count = 0; moding_en = 0 -> all six outputs 0 regardless of PIPDAT.

Source files
------------

// File: rtl/pipa_moding_source.sv
// PIPA pulse source for the AGC: a six-slot frame clocked by the synchronised PIPASW strobe,
// with per-axis signed frame credits selecting 4/2, 3/3 or 2/4 plus/minus moding each frame.
module pipa_moding_source #(
  parameter int CREDIT_W    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  SIM_CLK,
  input  logic                  SIM_RST,
  input  logic                  PIPASW,
  input  logic                  PIPDAT,
  input  logic                  moding_en,
  input  logic                  load_valid,
  input  logic [1:0]            load_axis,
  input  logic [CREDIT_W-1:0]   load_delta,
  output logic                  load_ready,
  output logic                  load_err,
  output logic                  PIPAXp,
  output logic                  PIPAXm,
  output logic                  PIPAYp,
  output logic                  PIPAYm,
  output logic                  PIPAZp,
  output logic                  PIPAZm,
  output logic [2:0]            busy,
  output logic [15:0]           frame_count,
  output logic [2:0]            dbg_slot,
  output logic [2:0][CREDIT_W-1:0] dbg_credit
);

  // Load handshake: a load is accepted on any rising SIM_CLK edge where load_valid
  // and load_ready are both high; load_ready is simply "not in reset", so there is no
  // back-pressure outside reset and nothing is held pending.
  localparam int CW2   = CREDIT_W + 2;
  localparam int SAT_I = (1 << (CREDIT_W - 1)) - 1;
  localparam logic signed [CW2-1:0] SAT_HI = CW2'(SAT_I);
  localparam logic signed [CW2-1:0] SAT_LO = CW2'(-SAT_I);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   slot_tick;
  logic                   frame_wrap;
  logic                   load_acc;

  logic [2:0]             slot_q;
  logic [2:0]             slot_d;

  logic signed [CREDIT_W-1:0] credit_q [3];
  logic signed [CREDIT_W-1:0] credit_d [3];
  logic        [2:0]          nplus_q  [3];
  logic        [2:0]          nplus_d  [3];
  logic signed [CW2-1:0]      sum_w    [3];
  logic signed [CW2-1:0]      step_w   [3];
  logic signed [CW2-1:0]      add_w    [3];
  logic signed [CREDIT_W-1:0] delta_s;

  logic [2:0] plus_w;
  logic [2:0] minus_w;

  assign delta_s    = load_delta;
  assign load_ready = ~SIM_RST;
  assign load_acc   = load_valid & load_ready;

  // PIPASW is asynchronous: a plain flop chain, then an edge flop for the rising edge.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q[0] <= PIPASW;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign slot_tick  = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign frame_wrap = slot_tick & (slot_q == 3'd5);

  // Slot sequencer: state register.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      slot_q <= 3'd0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Slot sequencer: next state.
  always_comb begin
    slot_d = slot_q;
    if (slot_tick) begin
      if (slot_q >= 3'd5) begin
        slot_d = 3'd0;
      end else begin
        slot_d = slot_q + 3'd1;
      end
    end
  end

  // Slot sequencer: outputs. PIPDAT gates combinationally with no register in its path.
  always_comb begin
    plus_w  = '0;
    minus_w = '0;
    for (int i = 0; i < 3; i++) begin
      plus_w[i]  = moding_en & PIPDAT & (slot_q <  nplus_q[i]);
      minus_w[i] = moding_en & PIPDAT & (slot_q >= nplus_q[i]);
    end
  end

  assign PIPAXp = plus_w[0];
  assign PIPAXm = minus_w[0];
  assign PIPAYp = plus_w[1];
  assign PIPAYm = minus_w[1];
  assign PIPAZp = plus_w[2];
  assign PIPAZm = minus_w[2];

  // Credit update: load delta and frame-boundary step are summed first and saturated once,
  // so -2^(CREDIT_W-1) can never be reached.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      step_w[i]   = '0;
      add_w[i]    = '0;
      sum_w[i]    = '0;
      credit_d[i] = credit_q[i];
      nplus_d[i]  = nplus_q[i];
      if (frame_wrap) begin
        if (credit_q[i] > 0) begin
          step_w[i]  = CW2'(1);
          nplus_d[i] = 3'd4;
        end else if (credit_q[i] < 0) begin
          step_w[i]  = '1;
          nplus_d[i] = 3'd2;
        end else begin
          nplus_d[i] = 3'd3;
        end
      end
      if (load_acc && (load_axis == 2'(i))) begin
        add_w[i] = CW2'(delta_s);
      end
      sum_w[i] = CW2'(credit_q[i]) + add_w[i] - step_w[i];
      if (sum_w[i] > SAT_HI) begin
        credit_d[i] = CREDIT_W'(SAT_HI);
      end else if (sum_w[i] < SAT_LO) begin
        credit_d[i] = CREDIT_W'(SAT_LO);
      end else begin
        credit_d[i] = CREDIT_W'(sum_w[i]);
      end
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      for (int i = 0; i < 3; i++) begin
        credit_q[i] <= '0;
        nplus_q[i]  <= 3'd3;
      end
      frame_count <= 16'd0;
      load_err    <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        credit_q[i] <= credit_d[i];
        nplus_q[i]  <= nplus_d[i];
      end
      if (frame_wrap) begin
        frame_count <= frame_count + 16'd1;
      end
      load_err <= load_acc & (load_axis == 2'd3);
    end
  end

  always_comb begin
    busy       = '0;
    dbg_credit = '0;
    for (int i = 0; i < 3; i++) begin
      busy[i]       = (credit_q[i] != '0);
      dbg_credit[i] = credit_q[i];
    end
  end

  assign dbg_slot = slot_q;

endmodule

// File: tb/tb_pipa_moding_source.sv
// Directed and randomized bench for pipa_moding_source against an arithmetic frame/credit model.
module tb_pipa_moding_source;
  localparam int W = 8;
  localparam int S = 2;

  logic SIM_CLK, SIM_RST, PIPASW, PIPDAT, moding_en, load_valid;
  logic [1:0] load_axis;
  logic [W-1:0] load_delta;
  logic load_ready, load_err;
  logic PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm;
  logic [2:0] busy;
  logic [15:0] frame_count;
  logic [2:0] dbg_slot;
  logic [2:0][W-1:0] dbg_credit;

  pipa_moding_source #(.CREDIT_W(W), .SYNC_STAGES(S)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .PIPASW(PIPASW), .PIPDAT(PIPDAT),
    .moding_en(moding_en), .load_valid(load_valid), .load_axis(load_axis),
    .load_delta(load_delta), .load_ready(load_ready), .load_err(load_err),
    .PIPAXp(PIPAXp), .PIPAXm(PIPAXm), .PIPAYp(PIPAYp), .PIPAYm(PIPAYm),
    .PIPAZp(PIPAZp), .PIPAZm(PIPAZm), .busy(busy), .frame_count(frame_count),
    .dbg_slot(dbg_slot), .dbg_credit(dbg_credit)
  );

  // clock/reset block
  initial SIM_CLK = 1'b0;
  always #5 SIM_CLK = ~SIM_CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model: frame credits, latched patterns, slot and frame number
  int mc[3];
  int mnp[3];
  int mslot;
  int mframe;
  int pcnt[3];
  int mcnt[3];

  task automatic step();
    @(posedge SIM_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic int sgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0;
      mnp[i] = 3;
    end
    mslot = 0;
    mframe = 0;
  endtask

  task automatic model_tick(input bit ld, input int ax, input int d);
    if (mslot == 5) begin
      for (int i = 0; i < 3; i++) begin
        mnp[i] = 3 + 1 * sgn(mc[i]);
        if (mc[i] != 0) mnp[i] = 3 + sgn(mc[i]);
        mnp[i] = (mc[i] > 0) ? 4 : ((mc[i] < 0) ? 2 : 3);
        mc[i] = sat(mc[i] + ((ld && ax == i) ? d : 0) - sgn(mc[i]));
      end
      mframe = (mframe + 1) % 65536;
      mslot = 0;
    end else begin
      mslot++;
      if (ld && ax < 3) mc[ax] = sat(mc[ax] + d);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] c;
    chk({tag, ".slot"}, dbg_slot, mslot);
    chk({tag, ".frame"}, frame_count, mframe);
    chk({tag, ".busy"}, busy, {mc[2] != 0, mc[1] != 0, mc[0] != 0});
    for (int i = 0; i < 3; i++) begin
      c = dbg_credit[i];
      chk($sformatf("%s.credit%0d", tag, i), {{24{c[7]}}, c}, mc[i]);
    end
  endtask

  task automatic check_out(input bit pd);
    logic [5:0] obs, exp;
    PIPDAT = pd;
    #1;
    obs = {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp};
    exp = '0;
    for (int i = 0; i < 3; i++) begin
      exp[2*i]   = moding_en & pd & (mslot <  mnp[i]);
      exp[2*i+1] = moding_en & pd & (mslot >= mnp[i]);
      if (pd) begin
        pcnt[i] += int'(obs[2*i]);
        mcnt[i] += int'(obs[2*i+1]);
      end
    end
    chk("pulses", obs, exp);
    PIPDAT = 1'b0;
  endtask

  // driver: one PIPASW strobe, optionally with a load landing on the slot_tick cycle
  task automatic do_tick(input bit ld, input logic [1:0] ax, input int d);
    PIPASW = 1'b1;
    repeat (S) step();
    if (ld) begin
      load_valid = 1'b1;
      load_axis = ax;
      load_delta = d[7:0];
    end
    step();
    load_valid = 1'b0;
    model_tick(ld, int'(ax), d);
    PIPASW = 1'b0;
    repeat (S + 1) step();
    check_state("tick");
  endtask

  task automatic do_load(input logic [1:0] ax, input int d);
    load_valid = 1'b1;
    load_axis = ax;
    load_delta = d[7:0];
    step();
    load_valid = 1'b0;
    chk("load_err", load_err, ax == 2'd3);
    if (ax != 2'd3) mc[ax] = sat(mc[ax] + d);
    check_state("load");
    step();
    chk("load_err_clr", load_err, 1'b0);
  endtask

  task automatic run_slot();
    check_out(1'b1);
    do_tick(1'b0, 2'd0, 0);
  endtask

  task automatic run_frame();
    for (int i = 0; i < 3; i++) begin
      pcnt[i] = 0;
      mcnt[i] = 0;
    end
    repeat (6) run_slot();
  endtask

  task automatic do_reset(input int n);
    SIM_RST = 1'b1;
    load_valid = 1'b1;
    load_axis = 2'd0;
    load_delta = 8'd50;
    step();
    chk("rst.load_ready", load_ready, 1'b0);
    repeat (n) step();
    load_valid = 1'b0;
    model_reset();
    chk("rst.load_err", load_err, 1'b0);
    check_state("rst");
    check_out(1'b1);
    SIM_RST = 1'b0;
    step();
    chk("rel.load_ready", load_ready, 1'b1);
    check_state("rel");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, d;
    logic [1:0] ax;
    SIM_RST = 1'b1; PIPASW = 1'b0; PIPDAT = 1'b0; moding_en = 1'b1;
    load_valid = 1'b0; load_axis = 2'd0; load_delta = '0;
    model_reset();
    do_reset(3);

    // two idle frames: 3/3 moding on every axis
    for (int f = 0; f < 2; f++) begin
      run_frame();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("idle.plus%0d", i), pcnt[i], 3);
        chk($sformatf("idle.minus%0d", i), mcnt[i], 3);
      end
    end
    chk("idle.frames", frame_count, 16'd2);

    // X +2 mid-frame: two 4/2 frames then back to 3/3
    do_reset(2);
    repeat (3) run_slot();
    do_load(2'd0, 2);
    repeat (3) run_slot();
    chk("x2.busy_f1", busy[0], 1'b1);
    run_frame();
    chk("x2.f1.xp", pcnt[0], 4);
    chk("x2.f1.xm", mcnt[0], 2);
    chk("x2.f1.yp", pcnt[1], 3);
    chk("x2.f1.zp", pcnt[2], 3);
    chk("x2.busy_f2", busy[0], 1'b0);
    run_frame();
    chk("x2.f2.xp", pcnt[0], 4);
    chk("x2.f2.xm", mcnt[0], 2);
    run_frame();
    chk("x2.f3.xp", pcnt[0], 3);
    chk("x2.f3.xm", mcnt[0], 3);

    // saturation at both rails
    do_load(2'd2, 127);
    do_load(2'd2, 5);
    chk("sat.z", {{24{dbg_credit[2][7]}}, dbg_credit[2]}, 32'sd127);
    do_load(2'd1, -128);
    chk("sat.y", {{24{dbg_credit[1][7]}}, dbg_credit[1]}, -32'sd127);

    // invalid axis
    do_load(2'd3, 10);
    chk("inv.z", {{24{dbg_credit[2][7]}}, dbg_credit[2]}, 32'sd127);
    chk("inv.x", dbg_credit[0], 8'd0);

    // load coinciding with the frame-boundary step
    do_reset(1);
    do_load(2'd0, 3);
    repeat (5) run_slot();
    check_out(1'b1);
    do_tick(1'b1, 2'd0, 1);
    chk("coin.x", dbg_credit[0], 8'd3);
    run_frame();
    chk("coin.xp", pcnt[0], 4);
    chk("coin.xm", mcnt[0], 2);

    // reset mid-frame, then output masking
    do_reset(1);
    do_load(2'd0, 5);
    repeat (4) run_slot();
    chk("mid.slot4", dbg_slot, 3'd4);
    SIM_RST = 1'b1;
    repeat (2) step();
    model_reset();
    SIM_RST = 1'b0;
    step();
    chk("mid.slot", dbg_slot, 3'd0);
    chk("mid.credit", dbg_credit[0], 8'd0);
    chk("mid.frame", frame_count, 16'd0);
    run_frame();
    chk("mid.xp", pcnt[0], 3);
    chk("mid.xm", mcnt[0], 3);
    moding_en = 1'b0;
    check_out(1'b1);
    chk("mask.hi", {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp}, 6'd0);
    PIPDAT = 1'b1;
    #1;
    chk("mask.hi2", {PIPAZm, PIPAZp, PIPAYm, PIPAYp, PIPAXm, PIPAXp}, 6'd0);
    PIPDAT = 1'b0;
    do_tick(1'b0, 2'd0, 0);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 19);
      moding_en = ($urandom_range(0, 3) != 0);
      ax = 2'($urandom_range(0, 3));
      d = int'($urandom_range(0, 255)) - 128;
      if (r < 6) begin
        do_load(ax, d);
      end else if (r < 10) begin
        check_out(1'($urandom_range(0, 1)));
        do_tick(1'b1, ax, d);
      end else if (r < 19) begin
        run_slot();
      end else begin
        do_reset(1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
